// File: rtl/sprite_palette_lut_pkg.sv
// Purpose : shared colour type and helpers for the sprite palette lookup.
// Contents: PAL_CH_W  default bits per colour channel
//           rgb_t     packed {r,g,b} colour, r in the most significant field
//           dim_rgb   halves every channel (floor) for the dimmed-sprite effect
package palette_pkg;

  localparam int PAL_CH_W = 4;

  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb_t;

  // Shift each channel right by one; the dropped LSB gives floor rounding.
  function automatic rgb_t dim_rgb(input rgb_t c);
    rgb_t d;
    d.r = {1'b0, c.r[PAL_CH_W-1:1]};
    d.g = {1'b0, c.g[PAL_CH_W-1:1]};
    d.b = {1'b0, c.b[PAL_CH_W-1:1]};
    return d;
  endfunction

endpackage

// File: rtl/sprite_palette_lut_ram.sv
// Purpose : simple dual-port palette storage, one write port and one
//           registered read port, read-first on an address collision.
// Ports   : Clk      clock
//           i_we     write strobe
//           i_waddr  write address
//           i_wdata  write data
//           i_raddr  read address, data appears on o_rdata after one edge
//           o_rdata  registered read data (old contents on a same-address write)
module palette_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              Clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_wr_ok;
  logic              w_rd_ok;

  // Addresses beyond the populated depth (possible with a single bank) are ignored.
  assign w_wr_ok = i_we & ({1'b0, i_waddr} < L_DEPTH);
  assign w_rd_ok = ({1'b0, i_raddr} < L_DEPTH);

  // Storage write and registered read; the non-blocking read returns pre-write data.
  always_ff @(posedge Clk) begin
    if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (w_rd_ok) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sprite_palette_lut.sv
// Purpose : pipelined, run-time writable colour lookup for sprite pixel
//           indices with a transparency key and a dim mode.
// Ports   : Clk, Reset               pixel clock, synchronous active-high reset
//           px_valid_in/bank/index   lookup request ({bank,index} addresses the RAM)
//           px_dim                   halve output brightness
//           px_valid_out             result valid, two cycles after the request
//           px_opaque, red/green/blue result; held while px_valid_out is low
//           wr_en/bank/index/rgb     palette write, accepted only when wr_ready
//           wr_ready, init_busy      clear sequence status after reset
module sprite_palette_lut
  import palette_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int INDEX_W     = 8,
  parameter int CH_W        = PAL_CH_W,
  parameter int TRANS_INDEX = 0,
  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                px_valid_in,
  input  logic [BANK_W-1:0]   px_bank,
  input  logic [INDEX_W-1:0]  px_index,
  input  logic                px_dim,
  output logic                px_valid_out,
  output logic                px_opaque,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0]   wr_rgb,
  output logic                wr_ready,
  output logic                init_busy
);

  localparam int ADDR_W = BANK_W + INDEX_W;
  localparam int DEPTH  = NUM_BANKS * (2 ** INDEX_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic               r_busy;
  logic [ADDR_W-1:0]  r_init_cnt;
  logic               r_s1_valid;
  logic [INDEX_W-1:0] r_s1_index;
  logic               r_s1_dim;
  logic               r_s1_busy;
  logic               r_valid_out;
  logic               r_opaque;
  rgb_t               r_rgb;

  logic               w_ram_we;
  logic [ADDR_W-1:0]  w_ram_waddr;
  logic [3*CH_W-1:0]  w_ram_wdata;
  logic [3*CH_W-1:0]  w_ram_rdata;
  rgb_t               w_stored;
  rgb_t               w_s2_rgb;
  logic               w_s2_opaque;

  // Clear sequence: one entry per cycle from address 0, busy drops after the last one.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_busy     <= 1'b1;
      r_init_cnt <= '0;
    end else if (r_busy) begin
      if (r_init_cnt == LAST_ADDR) begin
        r_busy <= 1'b0;
      end else begin
        r_init_cnt <= r_init_cnt + ADDR_W'(1);
      end
    end else begin
      r_init_cnt <= r_init_cnt;
    end
  end

  // Write port mux: the clear sequence owns the port while busy, user writes are dropped.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = '0;
    w_ram_wdata = '0;
    if (Reset) begin
      w_ram_we = 1'b0;
    end else if (r_busy) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_init_cnt;
    end else begin
      w_ram_we    = wr_en;
      w_ram_waddr = {wr_bank, wr_index};
      w_ram_wdata = wr_rgb;
    end
  end

  palette_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (3 * CH_W)
  ) u_ram (
    .Clk     (Clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr ({px_bank, px_index}),
    .o_rdata (w_ram_rdata)
  );

  // Stage 1 sidebands travel alongside the registered RAM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= px_valid_in;
    end
    r_s1_index <= px_index;
    r_s1_dim   <= px_dim;
    r_s1_busy  <= r_busy;
  end

  assign w_stored = rgb_t'(w_ram_rdata);

  // Colour resolution: busy or transparent lookups yield black/transparent before dimming.
  always_comb begin
    w_s2_rgb    = '0;
    w_s2_opaque = 1'b0;
    if (r_s1_busy || (r_s1_index == INDEX_W'(TRANS_INDEX))) begin
      w_s2_rgb    = '0;
      w_s2_opaque = 1'b0;
    end else if (r_s1_dim) begin
      w_s2_rgb    = dim_rgb(w_stored);
      w_s2_opaque = 1'b1;
    end else begin
      w_s2_rgb    = w_stored;
      w_s2_opaque = 1'b1;
    end
  end

  // Stage 2 output registers; colour only updates on a valid result to avoid idle toggling.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid_out <= 1'b0;
      r_opaque    <= 1'b0;
      r_rgb       <= '0;
    end else begin
      r_valid_out <= r_s1_valid;
      if (r_s1_valid) begin
        r_opaque <= w_s2_opaque;
        r_rgb    <= w_s2_rgb;
      end
    end
  end

  assign px_valid_out = r_valid_out;
  assign px_opaque    = r_opaque;
  assign red          = r_rgb.r;
  assign green        = r_rgb.g;
  assign blue         = r_rgb.b;
  assign init_busy    = r_busy;
  assign wr_ready     = ~r_busy;

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Self-checking bench for sprite_palette_lut (default parameters: 4 banks,
// 256 entries per bank, 4-bit channels, transparent index 0).
module tb_sprite_palette_lut;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        px_valid_in;
  logic [1:0]  px_bank;
  logic [7:0]  px_index;
  logic        px_dim;
  logic        px_valid_out;
  logic        px_opaque;
  logic [3:0]  red, green, blue;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [7:0]  wr_index;
  logic [11:0] wr_rgb;
  logic        wr_ready;
  logic        init_busy;

  sprite_palette_lut dut (
    .Clk(Clk), .Reset(Reset),
    .px_valid_in(px_valid_in), .px_bank(px_bank), .px_index(px_index), .px_dim(px_dim),
    .px_valid_out(px_valid_out), .px_opaque(px_opaque),
    .red(red), .green(green), .blue(blue),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .wr_ready(wr_ready), .init_busy(init_busy)
  );

  always #5 Clk = ~Clk;

  typedef struct { bit v; bit [11:0] rgb; bit op; } res_t;
  typedef struct { int due; bit [11:0] rgb; bit op; string name; } pend_t;
  typedef struct {
    bit we; int wb; int wi; logic [11:0] wd;
    bit vld; int bank; int idx; bit dim;
    bit chk; logic [11:0] erg; bit eop;
  } vec_t;

  // Reference state: palette contents, remaining clear cycles, pipeline and held output.
  logic [11:0] m_mem [1024];
  int          m_left = 0;
  res_t        e_prev = '{v: 1'b0, rgb: 12'h000, op: 1'b0};
  bit [11:0]   hold_rgb = 12'h000;
  bit          hold_op  = 1'b0;
  int          cyc = 0;
  pend_t       pq[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit [3:0] half(input bit [3:0] c);
    return 4'(c / 2);
  endfunction

  function automatic res_t lookup_model(input int bank, input int idx, input bit dim);
    res_t r;
    bit [11:0] c;
    r.v = 1'b1;
    if (m_left > 0 || idx == 0) begin
      r.rgb = 12'h000;
      r.op  = 1'b0;
    end else begin
      c    = m_mem[bank * 256 + idx];
      r.op = 1'b1;
      if (dim) r.rgb = {half(c[11:8]), half(c[7:4]), half(c[3:0])};
      else     r.rgb = c;
    end
    return r;
  endfunction

  // One clock cycle of stimulus, reference update and full output comparison.
  task automatic cycle(input bit rst, input bit vld, input int bank, input int idx, input bit dim,
                       input bit we, input int wb, input int wi, input logic [11:0] wd);
    res_t cur;
    bit   ev;
    Reset = rst; px_valid_in = vld; px_bank = 2'(bank); px_index = 8'(idx); px_dim = dim;
    wr_en = we; wr_bank = 2'(wb); wr_index = 8'(wi); wr_rgb = wd;
    cur = '{v: 1'b0, rgb: 12'h000, op: 1'b0};
    if (!rst && vld) cur = lookup_model(bank, idx, dim);
    if (!rst && we && m_left == 0) m_mem[wb * 256 + wi] = wd;
    if (rst) begin
      m_left = 1024;
      foreach (m_mem[i]) m_mem[i] = 12'h000;
    end else if (m_left > 0) begin
      m_left--;
    end
    @(posedge Clk); #1;
    cyc++;
    if (rst) begin
      ev = 1'b0; hold_rgb = 12'h000; hold_op = 1'b0;
    end else begin
      ev = e_prev.v;
      if (e_prev.v) begin hold_rgb = e_prev.rgb; hold_op = e_prev.op; end
    end
    check("pipe", {16'h0, px_valid_out, px_opaque, red, green, blue, init_busy, wr_ready},
                  {16'h0, ev, hold_op, hold_rgb, (m_left > 0), (m_left == 0)});
    e_prev = rst ? '{v: 1'b0, rgb: 12'h000, op: 1'b0} : cur;
    while (pq.size() > 0 && pq[0].due == cyc) begin
      check(pq[0].name, {19'h0, px_valid_out, px_opaque, red, green, blue},
                        {19'h0, 1'b1, pq[0].op, pq[0].rgb});
      void'(pq.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 12'h000);
  endtask

  task automatic expect_at(input string name, input logic [11:0] rgb, input bit op);
    pq.push_back('{due: cyc + 2, rgb: rgb, op: op, name: name});
  endtask

  vec_t vt[10];
  int   busy_cycles;
  int   vcount;

  initial begin
    Reset = 1'b1; px_valid_in = 1'b0; px_bank = 2'd0; px_index = 8'd0; px_dim = 1'b0;
    wr_en = 1'b0; wr_bank = 2'd0; wr_index = 8'd0; wr_rgb = 12'h000;

    // Directed vectors: write, lookups with dim, transparency, read-first collision.
    vt[0] = '{1'b1, 1, 8'h25, 12'h776, 1'b0, 0, 0,     1'b0, 1'b0, 12'h000, 1'b0};
    vt[1] = '{1'b0, 0, 0,     12'h000, 1'b1, 1, 8'h25, 1'b0, 1'b1, 12'h776, 1'b1};
    vt[2] = '{1'b0, 0, 0,     12'h000, 1'b1, 1, 8'h25, 1'b1, 1'b1, 12'h333, 1'b1};
    vt[3] = '{1'b1, 2, 0,     12'hFFF, 1'b0, 0, 0,     1'b0, 1'b0, 12'h000, 1'b0};
    vt[4] = '{1'b0, 0, 0,     12'h000, 1'b1, 2, 0,     1'b0, 1'b1, 12'h000, 1'b0};
    vt[5] = '{1'b1, 0, 9,     12'h111, 1'b0, 0, 0,     1'b0, 1'b0, 12'h000, 1'b0};
    vt[6] = '{1'b1, 0, 9,     12'h532, 1'b1, 0, 9,     1'b0, 1'b1, 12'h111, 1'b1};
    vt[7] = '{1'b0, 0, 0,     12'h000, 1'b1, 0, 9,     1'b0, 1'b1, 12'h532, 1'b1};
    vt[8] = '{1'b0, 0, 0,     12'h000, 1'b1, 2, 0,     1'b1, 1'b1, 12'h000, 1'b0};
    vt[9] = '{1'b0, 0, 0,     12'h000, 1'b0, 0, 0,     1'b0, 1'b0, 12'h000, 1'b0};

    // Test 1: single reset cycle, then count busy cycles while idle.
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 12'h000);
    busy_cycles = (init_busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 1100; i++) begin
      idle(1);
      if (init_busy === 1'b1) busy_cycles++;
    end
    check("init_len", 32'(busy_cycles), 32'd1024);
    check("ready", {31'h0, wr_ready}, 32'd1);

    // Tests 2-4 from the vector table.
    for (int i = 0; i < 10; i++) begin
      if (vt[i].chk) expect_at($sformatf("vec%0d", i), vt[i].erg, vt[i].eop);
      cycle(1'b0, vt[i].vld, vt[i].bank, vt[i].idx, vt[i].dim, vt[i].we, vt[i].wb, vt[i].wi, vt[i].wd);
    end
    idle(2);

    // Random palette fill, then mixed random writes and lookups.
    for (int i = 0; i < 64; i++)
      cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, $urandom_range(3), $urandom_range(255), 12'($urandom));
    for (int i = 0; i < 200; i++)
      cycle(1'b0, 1'($urandom), $urandom_range(3), $urandom_range(255), 1'($urandom),
            1'($urandom), $urandom_range(3), $urandom_range(255), 12'($urandom));
    idle(2);

    // Test 5: 256 back-to-back lookups sweeping banks 0..3.
    vcount = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 1'b1, i / 64, i, 1'($urandom), 1'b0, 0, 0, 12'h000);
      if (px_valid_out === 1'b1) vcount++;
    end
    for (int i = 0; i < 2; i++) begin
      idle(1);
      if (px_valid_out === 1'b1) vcount++;
    end
    check("stream_len", 32'(vcount), 32'd256);

    // Test 6a: reset at init count 500, writes while busy must be dropped.
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 12'h000);
    for (int i = 0; i < 500; i++)
      cycle(1'b0, 1'($urandom), $urandom_range(3), $urandom_range(255), 1'b0,
            1'b1, $urandom_range(3), $urandom_range(255), 12'($urandom));
    cycle(1'b1, 1'b1, 1, 8'h25, 1'b0, 1'b0, 0, 0, 12'h000);
    check("rst_busy", {30'h0, init_busy, wr_ready}, {30'h0, 2'b10});
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1, 8'h25, 12'hABC);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 3, 8'hFF, 12'h123);
    idle(1030);
    expect_at("drop_a", 12'h000, 1'b1);
    cycle(1'b0, 1'b1, 1, 8'h25, 1'b0, 1'b0, 0, 0, 12'h000);
    expect_at("drop_b", 12'h000, 1'b1);
    cycle(1'b0, 1'b1, 3, 8'hFF, 1'b0, 1'b0, 0, 0, 12'h000);
    idle(2);

    // Test 6b: reset in the middle of a valid stream flushes the pipeline.
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, $urandom_range(3), $urandom_range(255), 1'($urandom),
            1'($urandom), $urandom_range(3), $urandom_range(255), 12'($urandom));
    cycle(1'b1, 1'b1, 1, 8'h25, 1'b0, 1'b0, 0, 0, 12'h000);
    check("flush0", {31'h0, px_valid_out}, 32'd0);
    cycle(1'b0, 1'b1, 1, 8'h25, 1'b0, 1'b0, 0, 0, 12'h000);
    check("flush1", {31'h0, px_valid_out}, 32'd0);
    check("restart", {31'h0, init_busy}, 32'd1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
